// File: rtl/cache_miss_ctrl.sv
// Blocking miss controller for a set-associative cache: lookup, line refill, tag update.
// Define CACHE_LFSR_VICTIM_EN to replace the round-robin victim policy with an 8-bit LFSR.
`timescale 1ns/1ps

module cache_miss_ctrl #(
  parameter int WAYS       = 4,
  parameter int SETS       = 256,
  parameter int TAG_LEN    = 20,
  parameter int LINE_WORDS = 4,
  localparam int WAY_W     = $clog2(WAYS),
  localparam int IDX_W     = $clog2(SETS),
  localparam int BEAT_W    = $clog2(LINE_WORDS),
  localparam int OFF_W     = $clog2(LINE_WORDS * 4)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  output logic [IDX_W-1:0]          tag_addr,
  input  logic [WAYS*TAG_LEN-1:0]   tag_dout,
  output logic                      tag_we,
  output logic [WAY_W-1:0]          tag_way,
  output logic [TAG_LEN-1:0]        tag_din,
  output logic                      rd_req,
  output logic [31:0]               rd_addr,
  input  logic                      rd_rdy,
  input  logic                      ret_valid,
  input  logic                      ret_last,
  input  logic [31:0]               ret_data,
  output logic                      data_we,
  output logic [WAY_W-1:0]          data_way,
  output logic [IDX_W-1:0]          data_index,
  output logic [BEAT_W-1:0]         data_offset,
  output logic [31:0]               data_wdata,
  output logic                      resp_valid,
  output logic                      resp_hit,
  output logic [WAY_W-1:0]          resp_way
);

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, UPDATE} state_t;

  state_t               state;
  logic [TAG_LEN-1:0]   lat_tag;
  logic [IDX_W-1:0]     lat_idx;
  logic [WAY_W-1:0]     victim;
  logic [BEAT_W-1:0]    beat;
  logic [WAYS-1:0]      valid [SETS];

  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic                 inv_found;
  logic [WAY_W-1:0]     inv_way;
  logic [WAY_W-1:0]     policy_way;
  logic [WAY_W-1:0]     victim_next;

  // Byte offset within the line is not needed by the controller.
  logic                 unused_offset;
  assign unused_offset = ^req_addr[OFF_W-1:0];

`ifdef CACHE_LFSR_VICTIM_EN
  logic [7:0] lfsr;
  logic       lfsr_fb;
  assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign policy_way = lfsr[WAY_W-1:0];
`else
  logic [WAY_W-1:0] rr;
  assign policy_way = rr;
`endif

  // Scan downwards so the lowest-numbered matching way wins in both searches.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[lat_idx][w] && (tag_dout[w*TAG_LEN +: TAG_LEN] == lat_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[lat_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim_next = inv_found ? inv_way : policy_way;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      lat_tag <= '0;
      lat_idx <= '0;
      victim  <= '0;
      beat    <= '0;
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
`ifdef CACHE_LFSR_VICTIM_EN
      lfsr    <= 8'h01;
`else
      rr      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_tag <= req_addr[OFF_W+IDX_W +: TAG_LEN];
            lat_idx <= req_addr[OFF_W +: IDX_W];
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state <= IDLE;
          end else begin
            victim <= victim_next;
            state  <= MISS;
`ifdef CACHE_LFSR_VICTIM_EN
            lfsr   <= {lfsr[6:0], lfsr_fb};
`else
            if (!inv_found) rr <= rr + 1'b1;
`endif
          end
        end
        MISS: begin
          if (rd_rdy) begin
            beat  <= '0;
            state <= REFILL;
          end
        end
        REFILL: begin
          // The memory may end the burst early; ret_last always closes the fill.
          if (ret_valid) begin
            beat <= beat + 1'b1;
            if (ret_last) state <= UPDATE;
          end
        end
        UPDATE: begin
          valid[lat_idx][victim] <= 1'b1;
          state                  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are suppressed while reset is held so an abandoned fill never commits.
  always_comb begin
    req_ready   = (state == IDLE);
    tag_addr    = (state == IDLE) ? req_addr[OFF_W +: IDX_W] : lat_idx;
    tag_we      = 1'b0;
    tag_way     = '0;
    tag_din     = '0;
    rd_req      = 1'b0;
    rd_addr     = '0;
    data_we     = 1'b0;
    data_way    = '0;
    data_index  = '0;
    data_offset = '0;
    data_wdata  = '0;
    resp_valid  = 1'b0;
    resp_hit    = 1'b0;
    resp_way    = '0;
    if (!reset) begin
      case (state)
        LOOKUP: begin
          if (hit) begin
            resp_valid = 1'b1;
            resp_hit   = 1'b1;
            resp_way   = hit_way;
          end
        end
        MISS: begin
          rd_req  = 1'b1;
          rd_addr = {lat_tag, lat_idx, {OFF_W{1'b0}}};
        end
        REFILL: begin
          if (ret_valid) begin
            data_we     = 1'b1;
            data_way    = victim;
            data_index  = lat_idx;
            data_offset = beat;
            data_wdata  = ret_data;
          end
        end
        UPDATE: begin
          tag_we     = 1'b1;
          tag_way    = victim;
          tag_din    = lat_tag;
          resp_valid = 1'b1;
          resp_way   = victim;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: directed scenarios then random traffic against a cache model.
`timescale 1ns/1ps

module tb_cache_miss_ctrl;

   localparam int WAYS       = 4;
   localparam int SETS       = 256;
   localparam int TAG_LEN    = 20;
   localparam int LINE_WORDS = 4;

   logic                    clk;
   logic                    reset;
   logic                    req_valid;
   logic                    req_ready;
   logic [31:0]             req_addr;
   logic [7:0]              tag_addr;
   logic [WAYS*TAG_LEN-1:0] tag_dout;
   logic                    tag_we;
   logic [1:0]              tag_way;
   logic [TAG_LEN-1:0]      tag_din;
   logic                    rd_req;
   logic [31:0]             rd_addr;
   logic                    rd_rdy;
   logic                    ret_valid;
   logic                    ret_last;
   logic [31:0]             ret_data;
   logic                    data_we;
   logic [1:0]              data_way;
   logic [7:0]              data_index;
   logic [1:0]              data_offset;
   logic [31:0]             data_wdata;
   logic                    resp_valid;
   logic                    resp_hit;
   logic [1:0]              resp_way;

   int checks = 0;
   int errors = 0;

   cache_miss_ctrl dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .tag_addr(tag_addr), .tag_dout(tag_dout),
      .tag_we(tag_we), .tag_way(tag_way), .tag_din(tag_din),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
      .data_we(data_we), .data_way(data_way), .data_index(data_index),
      .data_offset(data_offset), .data_wdata(data_wdata),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way)
   );

   always #5 clk = ~clk;

   // External tag RAM: combinational read at tag_addr, write on tag_we.
   logic [TAG_LEN-1:0] tagRam [SETS][WAYS];
   always @(posedge clk) if (tag_we) tagRam[tag_addr][tag_way] <= tag_din;

   // Assemble the flat tag bus from the RAM model for the currently addressed set.
   always_comb begin
      tag_dout = '0;
      for (int w = 0; w < WAYS; w++) tag_dout[w*TAG_LEN +: TAG_LEN] = tagRam[tag_addr][w];
   end

   // Reference cache state: which tag lives in which way, plus the replacement state.
   logic [TAG_LEN-1:0] mTag   [SETS][WAYS];
   bit                 mValid [SETS][WAYS];
   int                 mRr;
   int                 mLfsr;

   function automatic void modelReset();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) mValid[s][w] = 0;
      mRr   = 0;
      mLfsr = 1;
   endfunction

   function automatic void modelAccess(input logic [31:0] a, output bit hit, output int way);
      int idx;
      int inv;
      int pol;
      int fb;
      idx = int'(a[11:4]);
      hit = 0;
      way = 0;
      inv = -1;
      for (int w = WAYS - 1; w >= 0; w--)
         if (mValid[idx][w] && mTag[idx][w] == a[31:12]) begin hit = 1; way = w; end
      if (!hit) begin
         for (int w = WAYS - 1; w >= 0; w--) if (!mValid[idx][w]) inv = w;
`ifdef CACHE_LFSR_VICTIM_EN
         pol   = mLfsr % WAYS;
         fb    = ((mLfsr >> 7) ^ (mLfsr >> 5) ^ (mLfsr >> 4) ^ (mLfsr >> 3)) & 1;
         mLfsr = ((mLfsr << 1) | fb) & 255;
`else
         fb  = 0;
         pol = mRr;
         if (inv < 0) mRr = (mRr + 1) % WAYS;
`endif
         way = (inv >= 0) ? inv : pol;
      end
   endfunction

   task automatic checkOutput(input string name, input bit ok,
                              input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Hold reset for a number of cycles with every input shouting, then release.
   task automatic doReset(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         reset = 1; req_valid = 1; req_addr = $urandom; rd_rdy = 1;
         ret_valid = 1; ret_last = 1; ret_data = $urandom;
         #1;
         checkOutput("rst_tag_we", tag_we === 1'b0, 64'(tag_we), 64'(0));
         checkOutput("rst_data_we", data_we === 1'b0, 64'(data_we), 64'(0));
         checkOutput("rst_rd_req", rd_req === 1'b0, 64'(rd_req), 64'(0));
         checkOutput("rst_resp_valid", resp_valid === 1'b0, 64'(resp_valid), 64'(0));
         if (c > 0) begin
            checkOutput("rst_req_ready", req_ready === 1'b1, 64'(req_ready), 64'(1));
            checkOutput("rst_tag_addr", tag_addr === req_addr[11:4], 64'(tag_addr), 64'(req_addr[11:4]));
         end
      end
      @(negedge clk);
      reset = 0; req_valid = 0; rd_rdy = 0; ret_valid = 0; ret_last = 0;
      modelReset();
      #1;
      checkOutput("post_rst_ready", req_ready === 1'b1, 64'(req_ready), 64'(1));
      checkOutput("post_rst_tag_we", tag_we === 1'b0, 64'(tag_we), 64'(0));
      checkOutput("post_rst_data_we", data_we === 1'b0, 64'(data_we), 64'(0));
      checkOutput("post_rst_rd_req", rd_req === 1'b0, 64'(rd_req), 64'(0));
      checkOutput("post_rst_resp_valid", resp_valid === 1'b0, 64'(resp_valid), 64'(0));
      checkOutput("post_rst_rd_addr", rd_addr === 32'h0, 64'(rd_addr), 64'(0));
   endtask

   // One full request: accept, lookup, and on a miss the fill and tag update.
   // lastBeat = beat on which ret_last is raised; abortBeat != 0 resets after that beat.
   task automatic applyStimulus(input logic [31:0] addr, input int rdyDelay,
                                input int lastBeat, input int abortBeat);
      bit          hit;
      int          way;
      logic [7:0]  idx;
      logic [19:0] tg;
      logic [31:0] line;
      logic [31:0] wd;
      idx  = addr[11:4];
      tg   = addr[31:12];
      line = {tg, idx, 4'h0};

      @(negedge clk);
      req_valid = 1; req_addr = addr; rd_rdy = 0; ret_valid = 0; ret_last = 0;
      #1;
      checkOutput("idle_ready", req_ready === 1'b1, 64'(req_ready), 64'(1));
      checkOutput("idle_tag_addr", tag_addr === idx, 64'(tag_addr), 64'(idx));
      checkOutput("idle_tag_we", tag_we === 1'b0, 64'(tag_we), 64'(0));
      checkOutput("idle_resp_valid", resp_valid === 1'b0, 64'(resp_valid), 64'(0));

      @(negedge clk);
      req_valid = 0; req_addr = $urandom; rd_rdy = 1; ret_valid = 1; ret_last = 1;
      #1;
      modelAccess(addr, hit, way);
      checkOutput("lookup_ready", req_ready === 1'b0, 64'(req_ready), 64'(0));
      checkOutput("lookup_tag_addr", tag_addr === idx, 64'(tag_addr), 64'(idx));
      checkOutput("lookup_resp_valid", resp_valid === hit, 64'(resp_valid), 64'(hit));
      checkOutput("lookup_data_we", data_we === 1'b0, 64'(data_we), 64'(0));
      checkOutput("lookup_rd_req", rd_req === 1'b0, 64'(rd_req), 64'(0));
      if (hit) begin
         checkOutput("hit_flag", resp_hit === 1'b1, 64'(resp_hit), 64'(1));
         checkOutput("hit_way", resp_way === 2'(way), 64'(resp_way), 64'(way));
         rd_rdy = 0; ret_valid = 0; ret_last = 0;
         return;
      end

      for (int c = 0; c <= rdyDelay; c++) begin
         @(negedge clk);
         rd_rdy = (c == rdyDelay); ret_valid = 1; ret_last = 1; ret_data = $urandom;
         #1;
         checkOutput("miss_rd_req", rd_req === 1'b1, 64'(rd_req), 64'(1));
         checkOutput("miss_rd_addr", rd_addr === line, 64'(rd_addr), 64'(line));
         checkOutput("miss_ready", req_ready === 1'b0, 64'(req_ready), 64'(0));
         checkOutput("miss_data_we", data_we === 1'b0, 64'(data_we), 64'(0));
         checkOutput("miss_resp_valid", resp_valid === 1'b0, 64'(resp_valid), 64'(0));
      end

      for (int b = 0; b < lastBeat; b++) begin
         if ($urandom_range(0, 2) == 0) begin
            @(negedge clk);
            ret_valid = 0; ret_last = 0; rd_rdy = 1;
            #1;
            checkOutput("gap_data_we", data_we === 1'b0, 64'(data_we), 64'(0));
            checkOutput("refill_rd_req", rd_req === 1'b0, 64'(rd_req), 64'(0));
         end
         @(negedge clk);
         wd = $urandom;
         ret_valid = 1; ret_last = (b == lastBeat - 1); ret_data = wd; rd_rdy = 0;
         #1;
         checkOutput("beat_data_we", data_we === 1'b1, 64'(data_we), 64'(1));
         checkOutput("beat_data_way", data_way === 2'(way), 64'(data_way), 64'(way));
         checkOutput("beat_data_index", data_index === idx, 64'(data_index), 64'(idx));
         checkOutput("beat_data_offset", data_offset === 2'(b % LINE_WORDS),
                     64'(data_offset), 64'(b % LINE_WORDS));
         checkOutput("beat_data_wdata", data_wdata === wd, 64'(data_wdata), 64'(wd));
         checkOutput("beat_tag_we", tag_we === 1'b0, 64'(tag_we), 64'(0));
         if (abortBeat != 0 && b == abortBeat - 1) begin
            doReset(2);
            return;
         end
      end

      @(negedge clk);
      ret_valid = 0; ret_last = 0;
      #1;
      checkOutput("upd_tag_we", tag_we === 1'b1, 64'(tag_we), 64'(1));
      checkOutput("upd_tag_way", tag_way === 2'(way), 64'(tag_way), 64'(way));
      checkOutput("upd_tag_din", tag_din === tg, 64'(tag_din), 64'(tg));
      checkOutput("upd_tag_addr", tag_addr === idx, 64'(tag_addr), 64'(idx));
      checkOutput("upd_resp_valid", resp_valid === 1'b1, 64'(resp_valid), 64'(1));
      checkOutput("upd_resp_hit", resp_hit === 1'b0, 64'(resp_hit), 64'(0));
      checkOutput("upd_resp_way", resp_way === 2'(way), 64'(resp_way), 64'(way));
      checkOutput("upd_data_we", data_we === 1'b0, 64'(data_we), 64'(0));
      mValid[idx][way] = 1;
      mTag[idx][way]   = tg;
   endtask

   // Watchdog: abort the run if the sequence never finishes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   // Directed scenarios from the verification requirements, then random traffic.
   initial begin
      logic [7:0] setPool [3];
      logic [31:0] a;
      setPool = '{8'h23, 8'h40, 8'hFF};
      clk = 0; reset = 1; req_valid = 0; req_addr = '0;
      rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = '0;
      modelReset();

      doReset(3);
      applyStimulus(32'h0000_1230, 1, 4, 0);
      applyStimulus(32'h0000_1234, 0, 4, 0);

      doReset(2);
      for (int t = 0; t < 5; t++)
         applyStimulus({20'(t + 10), 8'h23, 4'h0}, (t == 2) ? 10 : 0, 4, 0);
      applyStimulus({20'd10, 8'h23, 4'h8}, 0, 4, 0);

      applyStimulus(32'h0000_5670, 2, 4, 2);
      applyStimulus(32'h0000_5670, 0, 4, 0);

      applyStimulus(32'h0000_9990, 0, 2, 0);
      applyStimulus(32'h0000_999C, 0, 4, 0);

      for (int i = 0; i < 40; i++) begin
         a = {20'($urandom_range(1, 6)), setPool[$urandom_range(0, 2)], 4'($urandom)};
         applyStimulus(a, $urandom_range(0, 3), $urandom_range(1, 4),
                       ($urandom_range(0, 9) == 0) ? 1 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
